// File: rtl/afifo_if.sv
// rtl/afifo_if.sv - handshake bundle between a FIFO and its producer/consumer
//
// Purpose: groups the write and read handshake signals of afifo so that a
// single bus port carries them. The FIFO side uses the slave modport; the
// agent driving writes and reads uses the master modport.
//
// Signals:
//   wren   - write request (master -> slave)
//   wdata  - write data word, dsize bits (master -> slave)
//   wfull  - FIFO holds 2^asize entries (slave -> master)
//   rden   - read request (master -> slave)
//   rdata  - registered read data, dsize bits (slave -> master)
//   rempty - FIFO holds no entries (slave -> master)

interface afifo_if #(
  parameter int dsize = 8
);

  logic             wren;
  logic [dsize-1:0] wdata;
  logic             wfull;
  logic             rden;
  logic [dsize-1:0] rdata;
  logic             rempty;

  modport master (
    output wren,
    output wdata,
    output rden,
    input  wfull,
    input  rdata,
    input  rempty
  );

  modport slave (
    input  wren,
    input  wdata,
    input  rden,
    output wfull,
    output rdata,
    output rempty
  );

endinterface

// File: rtl/afifo.sv
// rtl/afifo.sv - single-clock FIFO with wrap-bit pointers and registered read data
//
// Purpose: rate-smoothing buffer between a producer and a consumer that share
// the clock wclk. Storage is a 2^asize-entry register array; occupancy is
// tracked by (asize+1)-bit write/read pointers whose MSB is a wrap bit, so
// full and empty are told apart without a separate counter.
//
// Ports:
//   wclk   - the single clock; all state updates on its rising edge
//   wrstn  - asynchronous active-low reset of pointers and rdata
//   bus    - afifo_if slave modport:
//              wren/wdata  write request and data (ignored while wfull)
//              rden        read request (ignored while rempty)
//              rdata       read word, valid after the edge that accepts rden
//              wfull       2^asize entries stored
//              rempty      no entries stored
//
// Parameters:
//   dsize  - data word width in bits; must match the interface instance
//   asize  - address width; depth is 2^asize entries

module afifo #(
  parameter int dsize = 8,
  parameter int asize = 4
) (
  input  logic   wclk,
  input  logic   wrstn,
  afifo_if.slave bus
);

  localparam int depth = 1 << asize;

  logic [dsize-1:0] mem [depth];

  logic [asize:0]   wptr;
  logic [asize:0]   rptr;
  logic [dsize-1:0] rdata_q;

  logic             full;
  logic             empty;
  logic             wr_accept;
  logic             rd_accept;
  logic [asize-1:0] waddr;
  logic [asize-1:0] raddr;

  assign waddr = wptr[asize-1:0];
  assign raddr = rptr[asize-1:0];

  // Equal pointers mean empty; equal addresses with differing wrap bits mean
  // the writer has lapped the reader exactly once, i.e. full.
  assign empty = (wptr == rptr);
  assign full  = (wptr[asize] != rptr[asize]) && (waddr == raddr);

  // Both requests are qualified by the flags as they stand before the edge,
  // so a simultaneous write into an empty FIFO is not bypassed to rdata and
  // a simultaneous write into a full FIFO is dropped while the read proceeds.
  assign wr_accept = bus.wren && !full;
  assign rd_accept = bus.rden && !empty;

  // Storage is not reset: after reset the pointers are equal, so no stale
  // entry can be read before it has been rewritten.
  always_ff @(posedge wclk) begin
    if (wr_accept) begin
      mem[waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      wptr <= '0;
    end else if (wr_accept) begin
      wptr <= wptr + 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      rptr    <= '0;
      rdata_q <= '0;
    end else if (rd_accept) begin
      rptr    <= rptr + 1'b1;
      rdata_q <= mem[raddr];
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rempty = empty;
  assign bus.wfull  = full;

endmodule

// File: tb/tb_afifo.sv
// tb/tb_afifo.sv - scoreboard bench for afifo (dsize=8, asize=3)

module tb_afifo;

  localparam int dsize = 8;
  localparam int asize = 3;
  localparam int depth = 1 << asize;

  logic wclk;
  logic wrstn;

  afifo_if #(.dsize(dsize)) bus ();

  afifo #(.dsize(dsize), .asize(asize)) dut (
    .wclk  (wclk),
    .wrstn (wrstn),
    .bus   (bus.slave)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [dsize-1:0] sb [$];
  logic [dsize-1:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus. The model decides acceptance from its own
  // occupancy before the edge, then compares rdata and flags after it.
  task automatic cycle(input string tag, input logic w, input logic [dsize-1:0] d, input logic r);
    logic acc_w;
    logic acc_r;
    logic [dsize-1:0] exp_r;
    acc_w = w && (sb.size() != depth);
    acc_r = r && (sb.size() != 0);
    exp_r = last_rdata;
    if (acc_r) exp_r = sb.pop_front();
    if (acc_w) sb.push_back(d);
    bus.wren  = w;
    bus.wdata = d;
    bus.rden  = r;
    @(posedge wclk);
    #1;
    bus.wren = 1'b0;
    bus.rden = 1'b0;
    check({tag, ".rdata"},  32'(bus.rdata),  32'(exp_r));
    check({tag, ".rempty"}, 32'(bus.rempty), 32'(sb.size() == 0));
    check({tag, ".wfull"},  32'(bus.wfull),  32'(sb.size() == depth));
    last_rdata = exp_r;
  endtask

  initial begin
    wrstn      = 1'b0;
    bus.wren   = 1'b0;
    bus.wdata  = '0;
    bus.rden   = 1'b0;
    last_rdata = '0;

    repeat (2) @(posedge wclk);
    #1;
    check("reset.rempty", 32'(bus.rempty), 32'd1);
    check("reset.wfull",  32'(bus.wfull),  32'd0);
    check("reset.rdata",  32'(bus.rdata),  32'd0);
    @(negedge wclk);
    wrstn = 1'b1;
    @(posedge wclk);
    #1;

    for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 8'(i), 1'b0);
    cycle("write_full_drop", 1'b1, 8'hAA, 1'b0);

    for (int i = 0; i < 4; i++) cycle("read4", 1'b0, 8'h00, 1'b1);

    for (int i = 8; i < 12; i++) cycle("wrap_write", 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 8'h00, 1'b1);

    cycle("read_empty", 1'b0, 8'h00, 1'b1);
    cycle("read_empty", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 4; i++) cycle("mid_fill", 1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 6; i++) cycle("simul_mid", 1'b1, 8'(8'h30 + i), 1'b1);

    for (int i = 0; i < 4; i++) cycle("to_full", 1'b1, 8'(8'h40 + i), 1'b0);
    cycle("simul_full", 1'b1, 8'hEE, 1'b1);
    cycle("refill", 1'b1, 8'h50, 1'b0);
    for (int i = 0; i < 8; i++) cycle("drain2", 1'b0, 8'h00, 1'b1);
    cycle("simul_empty", 1'b1, 8'h66, 1'b1);
    for (int i = 0; i < 4; i++) cycle("five", 1'b1, 8'(8'h70 + i), 1'b0);

    // Asynchronous reset in the middle of a cycle with five entries stored.
    #2;
    wrstn = 1'b0;
    #1;
    check("async_reset.rempty", 32'(bus.rempty), 32'd1);
    check("async_reset.wfull",  32'(bus.wfull),  32'd0);
    check("async_reset.rdata",  32'(bus.rdata),  32'd0);
    sb.delete();
    last_rdata = '0;
    @(negedge wclk);
    wrstn = 1'b1;
    @(posedge wclk);
    #1;

    cycle("post_reset_w", 1'b1, 8'h5A, 1'b0);
    cycle("post_reset_r", 1'b0, 8'h00, 1'b1);
    cycle("post_reset_empty", 1'b0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
